// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared types and sizing constants for the round-robin bus arbiter.
// Revision: 1.0
// ============================================================================
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational rotate-priority encoder; first set req bit at or
//           above ptr, wrapping modulo N.
// Revision: 1.0
// ============================================================================
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = N_REQ,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] enc;

  // rot[0] is the requester sitting at ptr, so the LSB is the highest priority.
  always_comb begin
    logic [SEL_W-1:0] src;
    rot = '0;
    for (int i = 0; i < N; i++) begin
      src    = SEL_W'(i) + ptr;
      rot[i] = req[src];
    end
  end

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = SEL_W'(i);
      end
    end
  end

  assign valid = |req;
  // N is a power of two, so the SEL_W-bit add wraps modulo N.
  assign idx   = enc + ptr;

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_bus_arbiter8.sv
`default_nettype none
// ============================================================================
// Module  : rr_bus_arbiter8
// Brief   : Round-robin owner of a shared bus mux select with hold timeout and
//           a one-cycle turnaround between owners. All outputs registered.
// Revision: 1.0
// ============================================================================
module rr_bus_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int SEL_W    = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]    ONE_HOT0  = N'(1);

  arb_state_t       state, state_n;
  logic [N-1:0]     gnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             busy_n;
  logic             timeout_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [HC_W-1:0]  hold_cnt, hold_n;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             rel_hit;
  logic             hold_hit;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Voluntary release beats the hold limit when both occur in the same cycle.
  assign rel_hit  = done[sel] | ~req[sel];
  assign hold_hit = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    sel_n     = sel;
    busy_n    = busy;
    timeout_n = 1'b0;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = OWN;
          gnt_n   = ONE_HOT0 << pick_idx;
          sel_n   = pick_idx;
          busy_n  = 1'b1;
          hold_n  = '0;
        end
      end
      OWN: begin
        if (rel_hit || hold_hit) begin
          state_n   = TURN;
          gnt_n     = '0;
          busy_n    = 1'b0;
          ptr_n     = sel + SEL_W'(1);
          timeout_n = hold_hit & ~rel_hit;
        end else begin
          hold_n = hold_cnt + HC_W'(1);
        end
      end
      TURN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule : rr_bus_arbiter8
`default_nettype wire

// File: tb/tb_rr_bus_arbiter8.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_bus_arbiter8
// Brief   : Self-checking bench: behavioural arbiter model compared every
//           cycle, directed scenarios with literal expectations, random soak.
// Revision: 1.0
// ============================================================================
module tb_rr_bus_arbiter8;

  localparam int N        = 8;
  localparam int SEL_W    = 3;
  localparam int MAX_HOLD = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     done = '0;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;

  int errors = 0;
  int checks = 0;

  rr_bus_arbiter8 #(
    .N        (N),
    .SEL_W    (SEL_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = no owner, 1 = owning, 2 = turnaround.
  // m_held counts how many cycles the current owner has already been granted.
  int m_phase = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 0;
  bit model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
      model_ok = 1;
    end else begin
      m_to = 0;
      case (m_phase)
        0: begin
          bit found;
          found = 0;
          for (int k = 0; k < N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
              found   = 1;
              m_owner = (m_ptr + k) % N;
              m_phase = 1;
              m_held  = 1;
            end
          end
        end
        1: begin
          if (done[m_owner] || !req[m_owner]) begin
            m_phase = 2;
            m_ptr   = (m_owner + 1) % N;
          end else if (m_held == MAX_HOLD) begin
            m_phase = 2;
            m_ptr   = (m_owner + 1) % N;
            m_to    = 1;
          end else begin
            m_held++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [N-1:0] exp_gnt;
      logic [N-1:0] sel_oh;
      exp_gnt = (m_phase == 1) ? (N'(1) << m_owner) : '0;
      sel_oh  = N'(1) << sel;
      chk("no_x", 32'($isunknown({gnt, sel, busy, timeout})), 32'd0);
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("sel", 32'(sel), 32'(m_owner));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_busy_gnt", 32'(gnt != '0), 32'(busy));
      if (busy) chk("inv_gnt_sel", 32'(gnt), 32'(sel_oh));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held two cycles with all requesting
    reset = 1'b1; req = 8'hFF; done = '0;
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    step();
    chk("first_gnt", 32'(gnt), 32'h01);

    // 2: rotation through all eight, wrapping back to 0
    for (int k = 1; k <= 8; k++) begin
      done = N'(1) << ((k - 1) % 8);
      step();
      done = '0;
      chk("rot_turn_gnt", 32'(gnt), 32'h00);
      step();
      chk("rot_idle_gnt", 32'(gnt), 32'h00);
      step();
      chk("rot_gnt", 32'(gnt), 32'(N'(1) << (k % 8)));
    end

    // 3: skip/wrap from ptr=6
    reset = 1'b1; step(); reset = 1'b0;
    req = 8'h20;
    step();
    chk("sk_own5", 32'(gnt), 32'h20);
    done = 8'h20;
    step();
    done = '0; req = 8'b0000_0101;
    step(); step();
    chk("sk_gnt0", 32'(gnt), 32'h01);
    chk("sk_sel0", 32'(sel), 32'h0);
    done = 8'h01;
    step();
    done = '0;
    step(); step();
    chk("sk_gnt2", 32'(gnt), 32'h04);
    chk("sk_sel2", 32'(sel), 32'h2);

    // 4: timeout after exactly MAX_HOLD cycles, then regrant
    reset = 1'b1; step(); reset = 1'b0;
    req = 8'h08;
    step();
    chk("to_hold", 32'(gnt), 32'h08);
    for (int i = 1; i < MAX_HOLD; i++) begin
      step();
      chk("to_hold", 32'(gnt), 32'h08);
    end
    step();
    chk("to_rev_gnt", 32'(gnt), 32'h00);
    chk("to_pulse", 32'(timeout), 32'h1);
    step();
    chk("to_idle_gnt", 32'(gnt), 32'h00);
    chk("to_pulse_end", 32'(timeout), 32'h0);
    step();
    chk("to_regrant", 32'(gnt), 32'h08);

    // 5a: done[sel] on the last hold cycle releases without timeout
    for (int i = 1; i < MAX_HOLD; i++) step();
    done = 8'h08;
    step();
    done = '0;
    chk("sim_gnt", 32'(gnt), 32'h00);
    chk("sim_timeout", 32'(timeout), 32'h0);

    // 5b: foreign done ignored
    reset = 1'b1; step(); reset = 1'b0;
    req = 8'h20;
    step();
    done = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("foreign_done", 32'(gnt), 32'h20);
    end
    done = '0;

    // 6: reset mid-grant
    reset = 1'b1; req = 8'h10; step(); reset = 1'b0;
    step();
    chk("mr_own4", 32'(gnt), 32'h10);
    step();
    reset = 1'b1;
    step();
    chk("mr_gnt", 32'(gnt), 32'h00);
    chk("mr_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step();
    chk("mr_regrant", 32'(gnt), 32'h10);

    // Random soak; req changes occasionally so long holds and timeouts occur
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      if ($urandom_range(0, 5) == 0) done = N'(1) << $urandom_range(0, N - 1);
      else done = '0;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; req = '0; done = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rr_bus_arbiter8
`default_nettype wire
